bist_scheduler: RTL and testbench
=================================

// Module: bist_scheduler
// PURPOSE
//  Round-robin scheduler that shares one BIST session slot among N_UNITS functional units.
//  Each unit has its own idle detector; this block grants BIST to one eligible unit at a time.
//  Per unit, the handshake is a start pulse, then done/pass, or an abort when traffic returns.
//  Sits between the per-unit idle detectors and the BIST engines; results go to safety status.
// PARAMETERS
//  N_UNITS          4     number of units sharing the BIST slot (>=2)
//  COOLDOWN_CYCLES  8     idle cycles forced after every session end (>=1)
//  TIMEOUT_CYCLES   1024  max RUN length before watchdog abort (used only with BIST_TIMEOUT_EN)
//  CNT_WIDTH        8     width of the completed-session counter
//  UNIT_W (local) = $clog2(N_UNITS)
// PORTS
//  clk           in   1          system clock
//  rst           in   1          asynchronous, active-high reset
//  enable        in   1          scheduler enable; 0 = no new grants (running session continues)
//  idle_trigger  in   N_UNITS    per-unit "safe to BIST" from the idle detectors
//  system_valid  in   N_UNITS    per-unit functional activity
//  bist_done     in   N_UNITS    per-unit session complete (1-cycle pulse)
//  bist_pass     in   N_UNITS    per-unit result, sampled with bist_done
//  clear_status  in   1          synchronous clear of fail_status and timeout_status
//  bist_start    out  N_UNITS    one-hot 1-cycle start pulse
//  bist_abort    out  N_UNITS    one-hot 1-cycle abort pulse
//  active_unit   out  UNIT_W     index of granted unit (valid while busy)
//  busy          out  1          high in GRANT/RUN/COOLDOWN
//  fail_status   out  N_UNITS    sticky per-unit fail flags
//  session_cnt   out  CNT_WIDTH  completed (done-received) sessions, saturating
//  irq_fail      out  1          1-cycle pulse when any fail flag is newly set
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: state=IDLE, all outputs 0; rr pointer = N_UNITS-1, so unit 0 has first priority.
//  eligible[i] = idle_trigger[i] & ~system_valid[i].
//  IDLE: if enable & |eligible, pick the first eligible unit searching from ptr+1 with modulo wrap.
//    Latch it as active_unit, set ptr to it, go to GRANT.
//  GRANT (1 cycle): bist_start[active_unit]=1, then go to RUN. Latency from IDLE decision to start = 1 cycle.
//  RUN: wait for bist_done[active_unit]; done/abort from other units are ignored.
//    done: session_cnt+1 (sat at all-ones). If !bist_pass, set fail_status[active_unit] and pulse irq_fail next cycle.
//      Then go to COOLDOWN.
//    system_valid[active_unit] rises (done not present): bist_abort[active_unit]=1 next cycle, go to COOLDOWN.
//      An abort does not count as a session and sets no fail flag.
//    done and system_valid in the same cycle: done wins and is recorded; no abort.
//  COOLDOWN: counter loads COOLDOWN_CYCLES-1 and counts down; at 0 go to IDLE (exactly COOLDOWN_CYCLES cycles).
//  enable dropping mid-session: current session completes normally; no grant while enable=0.
//  clear_status in the same cycle as a new fail: the new fail wins (flag set, irq_fail pulses).
//  Reset mid-session: immediate return to IDLE; no abort pulse is issued.
//  bist_start/bist_abort are one-hot or zero; never both high in one cycle.
// CONFIGURATION
//  BIST_TIMEOUT_EN defined:
//    RUN watchdog counter; after TIMEOUT_CYCLES cycles in RUN without done, issue bist_abort.
//    Also sets fail_status and timeout_status[active_unit], pulses irq_fail, goes to COOLDOWN.
//    Extra output port timeout_status [N_UNITS], sticky, cleared by clear_status.
//  BIST_TIMEOUT_EN undefined: no watchdog and no timeout_status port; RUN waits indefinitely.
// TESTING
//  1. Reset, enable=1, idle_trigger=4'b0001, valid=0 -> bist_start=0001 one cycle after IDLE pick; busy=1.
//  2. All 4 eligible, every session done with pass=1 -> start order 0,1,2,3,0; session_cnt=5; fail_status=0.
//  3. Unit 2 in RUN, system_valid[2]=1 -> bist_abort=0100 next cycle; cooldown 8 cycles; session_cnt unchanged.
//  4. bist_done[1] with pass=0 in the same cycle as system_valid[1] -> fail_status[1]=1, irq_fail pulse, no abort.
//  5. Fail flag set, then clear_status=1 -> fail_status=0; session_cnt driven to 255 with CNT_WIDTH=8 stays 255.
//  6. BIST_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no done -> abort at RUN cycle 16; fail_status and timeout_status bits set.

Source files
------------

// File: rtl/bist_scheduler.sv
// Round-robin BIST slot scheduler for N_UNITS units.
// Optional RUN watchdog: define BIST_TIMEOUT_EN.
module bist_scheduler #(
    parameter int N_UNITS         = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [N_UNITS-1:0]           idle_trigger,
    input  logic [N_UNITS-1:0]           system_valid,
    input  logic [N_UNITS-1:0]           bist_done,
    input  logic [N_UNITS-1:0]           bist_pass,
    input  logic                         clear_status,
    output logic [N_UNITS-1:0]           bist_start,
    output logic [N_UNITS-1:0]           bist_abort,
    output logic [$clog2(N_UNITS)-1:0]   active_unit,
    output logic                         busy,
    output logic [N_UNITS-1:0]           fail_status,
    output logic [CNT_WIDTH-1:0]         session_cnt,
    output logic                         irq_fail
`ifdef BIST_TIMEOUT_EN
    ,
    output logic [N_UNITS-1:0]           timeout_status
`endif
);

    localparam int UNIT_W = $clog2(N_UNITS);
    localparam int CD_W   = $clog2(COOLDOWN_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMR_W  = (CD_W > TO_W) ? CD_W : TO_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_COOL  = 2'd3;

    logic [1:0]         state;
    logic [UNIT_W-1:0]  ptr;
    logic [TMR_W-1:0]   tmr;
    logic [N_UNITS-1:0] eligible;
    logic [N_UNITS-1:0] act_oh;
    logic [N_UNITS-1:0] pick_oh;
    logic [UNIT_W-1:0]  pick;
    logic               found;
    logic               done_hit;
    logic               pass_hit;
    logic               valid_hit;
    logic               to_fire;
    logic [N_UNITS-1:0] fail_set;
    logic [N_UNITS-1:0] fail_keep;
    int                 sel_idx;

    assign eligible = idle_trigger & ~system_valid;
    assign busy     = (state != S_IDLE);

    // Round-robin search starting just after the last granted unit.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        sel_idx = 0;
        for (int k = 1; k <= N_UNITS; k++) begin
            sel_idx = (int'(ptr) + k) % N_UNITS;
            if (!found && eligible[sel_idx]) begin
                found   = 1'b1;
                pick    = UNIT_W'(sel_idx);
            end
        end
        pick_oh[pick] = 1'b1;
    end

    // Decode events belonging to the granted unit only.
    always_comb begin
        act_oh              = '0;
        act_oh[active_unit] = 1'b1;
        done_hit            = |(bist_done & act_oh);
        pass_hit            = |(bist_pass & act_oh);
        valid_hit           = |(system_valid & act_oh);
`ifdef BIST_TIMEOUT_EN
        to_fire = (state == S_RUN) && !done_hit && !valid_hit && (tmr == '0);
`else
        to_fire = 1'b0;
`endif
        fail_set = '0;
        if ((state == S_RUN) && done_hit && !pass_hit)
            fail_set = act_oh;
        if (to_fire)
            fail_set = act_oh;
        fail_keep = clear_status ? '0 : fail_status;
    end

    // Session FSM, start/abort pulses and completed-session counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= UNIT_W'(N_UNITS - 1);
            active_unit <= '0;
            tmr         <= '0;
            bist_start  <= '0;
            bist_abort  <= '0;
            session_cnt <= '0;
        end else begin
            bist_start <= '0;
            bist_abort <= '0;
            unique case (state)
                S_IDLE: begin
                    if (enable && found) begin
                        active_unit <= pick;
                        ptr         <= pick;
                        bist_start  <= pick_oh;
                        state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    tmr   <= TMR_W'(TIMEOUT_CYCLES - 1);
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (done_hit) begin
                        if (session_cnt != '1)
                            session_cnt <= session_cnt + 1'b1;
                        tmr   <= TMR_W'(COOLDOWN_CYCLES - 1);
                        state <= S_COOL;
                    end else if (valid_hit || to_fire) begin
                        bist_abort <= act_oh;
                        tmr        <= TMR_W'(COOLDOWN_CYCLES - 1);
                        state      <= S_COOL;
                    end else if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_COOL: begin
                    if (tmr == '0)
                        state <= S_IDLE;
                    else
                        tmr <= tmr - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky fail flags; a new fail beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_status <= '0;
            irq_fail    <= 1'b0;
        end else begin
            fail_status <= fail_keep | fail_set;
            irq_fail    <= |(fail_set & ~fail_keep);
        end
    end

`ifdef BIST_TIMEOUT_EN
    // Sticky watchdog flags, cleared together with fail flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_status <= '0;
        else
            timeout_status <= (clear_status ? '0 : timeout_status)
                            | (to_fire ? act_oh : '0);
    end
`endif

endmodule

// File: tb/tb_bist_scheduler.sv
// Directed testbench for bist_scheduler.
// Covers round-robin, abort, fail/irq, clear, saturation, enable, reset.
module tb_bist_scheduler;

    localparam int N = 4;
`ifdef BIST_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         clear_status;
    logic [N-1:0] idle_trigger;
    logic [N-1:0] system_valid;
    logic [N-1:0] bist_done;
    logic [N-1:0] bist_pass;
    logic [N-1:0] bist_start;
    logic [N-1:0] bist_abort;
    logic [1:0]   active_unit;
    logic         busy;
    logic [N-1:0] fail_status;
    logic [7:0]   session_cnt;
    logic         irq_fail;
`ifdef BIST_TIMEOUT_EN
    logic [N-1:0] timeout_status;
`endif

    int checks   = 0;
    int failures = 0;
    int n;
    logic [N-1:0] seen;

    bist_scheduler #(
        .N_UNITS(N),
        .COOLDOWN_CYCLES(8),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .idle_trigger(idle_trigger),
        .system_valid(system_valid),
        .bist_done(bist_done),
        .bist_pass(bist_pass),
        .clear_status(clear_status),
        .bist_start(bist_start),
        .bist_abort(bist_abort),
        .active_unit(active_unit),
        .busy(busy),
        .fail_status(fail_status),
        .session_cnt(session_cnt),
        .irq_fail(irq_fail)
`ifdef BIST_TIMEOUT_EN
        ,
        .timeout_status(timeout_status)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        enable       = 1'b0;
        clear_status = 1'b0;
        idle_trigger = '0;
        system_valid = '0;
        bist_done    = '0;
        bist_pass    = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(input logic [N-1:0] exp, input string tag);
        int k = 0;
        while (bist_start == '0 && k < 50) begin
            tick();
            k++;
        end
        check(tag, bist_start, exp);
    endtask

    task automatic finish_session(input logic [N-1:0] u, input logic pass);
        tick();
        bist_done = u;
        bist_pass = pass ? u : '0;
        tick();
        bist_done = '0;
        bist_pass = '0;
    endtask

    task automatic cool_len(output int len);
        len = 0;
        while (busy && len < 40) begin
            len++;
            tick();
        end
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_start", bist_start, 0);
        check("rst_cnt", session_cnt, 0);
        check("rst_fail", fail_status, 0);

        // single eligible unit: start one cycle after pick
        enable       = 1'b1;
        idle_trigger = 4'b0001;
        tick();
        check("t1_start", bist_start, 4'b0001);
        check("t1_busy", busy, 1);
        check("t1_unit", active_unit, 0);
        idle_trigger = '0;
        finish_session(4'b0001, 1'b1);
        check("t1_cnt", session_cnt, 1);
        cool_len(n);
        check("t1_cool", n, 8);

        // round robin over all units from reset
        do_reset();
        enable       = 1'b1;
        idle_trigger = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start(4'b0001 << (k % 4), "t2_order");
            finish_session(4'b0001 << (k % 4), 1'b1);
            cool_len(n);
        end
        check("t2_cnt", session_cnt, 5);
        check("t2_fail", fail_status, 0);

        // abort on traffic return
        idle_trigger = 4'b0100;
        wait_start(4'b0100, "t3_start");
        tick();
        system_valid = 4'b0100;
        idle_trigger = '0;
        tick();
        system_valid = '0;
        check("t3_abort", bist_abort, 4'b0100);
        check("t3_nostart", bist_start, 0);
        cool_len(n);
        check("t3_cool", n, 8);
        check("t3_cnt", session_cnt, 5);
        check("t3_abort_end", bist_abort, 0);

        // done with fail and traffic in the same cycle
        idle_trigger = 4'b0010;
        wait_start(4'b0010, "t4_start");
        idle_trigger = '0;
        tick();
        bist_done    = 4'b0010;
        bist_pass    = 4'b0000;
        system_valid = 4'b0010;
        tick();
        bist_done    = '0;
        system_valid = '0;
        check("t4_noabort", bist_abort, 0);
        check("t4_fail", fail_status, 4'b0010);
        check("t4_irq", irq_fail, 1);
        check("t4_cnt", session_cnt, 6);
        tick();
        check("t4_irq_pulse", irq_fail, 0);
        check("t4_noabort2", bist_abort, 0);
        cool_len(n);

        // clear status
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("t5_clear", fail_status, 0);

        // clear racing a new fail
        idle_trigger = 4'b0010;
        wait_start(4'b0010, "t5_s1");
        idle_trigger = '0;
        finish_session(4'b0010, 1'b0);
        check("t5_fail1", fail_status, 4'b0010);
        cool_len(n);
        idle_trigger = 4'b0001;
        wait_start(4'b0001, "t5_s0");
        idle_trigger = '0;
        tick();
        bist_done    = 4'b0001;
        clear_status = 1'b1;
        tick();
        bist_done    = '0;
        clear_status = 1'b0;
        check("t5_race_fail", fail_status, 4'b0001);
        check("t5_race_irq", irq_fail, 1);
        check("t5_cnt8", session_cnt, 8);
        cool_len(n);

        // counter saturation
        idle_trigger = 4'b0001;
        for (int k = 0; k < 247; k++) begin
            n = 0;
            while (bist_start == '0 && n < 50) begin
                tick();
                n++;
            end
            finish_session(4'b0001, 1'b1);
            cool_len(n);
        end
        check("t5_cnt255", session_cnt, 255);
        wait_start(4'b0001, "t5_sat_start");
        finish_session(4'b0001, 1'b1);
        check("t5_sat", session_cnt, 255);
        cool_len(n);

        // no grants while disabled
        enable       = 1'b0;
        idle_trigger = 4'b1111;
        seen         = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen = seen | bist_start | {3'b000, busy};
        end
        check("t6_disabled", seen, 0);
        enable = 1'b1;
        wait_start(4'b0010, "t6_resume");
        idle_trigger = 4'b0100;
        finish_session(4'b0010, 1'b1);
        cool_len(n);

        // reset mid-session
        wait_start(4'b0100, "t7_start");
        tick();
        rst = 1'b1;
        #1;
        check("t7_busy", busy, 0);
        check("t7_abort", bist_abort, 0);
        check("t7_cnt", session_cnt, 0);
        rst = 1'b0;

`ifdef BIST_TIMEOUT_EN
        // watchdog
        do_reset();
        enable       = 1'b1;
        idle_trigger = 4'b0001;
        wait_start(4'b0001, "t8_start");
        idle_trigger = '0;
        tick();
        n = 0;
        while (bist_abort == '0 && n < 40) begin
            tick();
            n++;
        end
        check("t8_len", n, 16);
        check("t8_abort", bist_abort, 4'b0001);
        check("t8_fail", fail_status, 4'b0001);
        check("t8_to", timeout_status, 4'b0001);
        check("t8_irq", irq_fail, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
